img_line_feeder: RTL and testbench

Streaming source for the line-buffer controller of the edge-detection pipeline. It accepts packed 32-bit pixel words from an upstream ready/valid stream (DMA or ROM reader) and unpacks them into one 8-bit pixel per clock on the controller's `pixel_data`/`pixel_data_valid` input. It throttles itself with line credits. Each credit is one free line buffer downstream, and a credit is returned by the controller's per-line "line consumed" pulse.

---
 rtl/img_pkg.sv | 23 ++
 rtl/img_credit_ctr.sv | 48 ++++
 rtl/img_line_feeder.sv | 134 +++++++++++++
 tb/tb_img_line_feeder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared types and defaults for the image line feeder.
package img_pkg;

   localparam int unsigned LINE_W_DEF     = 512;
   localparam int unsigned NUM_LB_DEF     = 4;
   localparam int unsigned IMG_H_DEF      = 512;
   localparam int unsigned PIX_W          = 8;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned BYTES_PER_WORD = WORD_W / PIX_W;

   typedef enum logic {
      FILL = 1'b0,
      SEND = 1'b1
   } feed_state_e;

   typedef logic [PIX_W-1:0] pixel_t;

   // Counter width for a 0..n-1 range, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/img_credit_ctr.sv
// Downstream line-buffer credit counter with a sticky overflow flag.
module img_credit_ctr
   import img_pkg::*;
#(
   parameter int unsigned NUM_LB = NUM_LB_DEF
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic take,
   input  logic give,
   output logic avail,
   output logic err
);

   localparam int unsigned CW = $clog2(NUM_LB + 1);

   logic [CW-1:0] credit_q, credit_d;
   logic          err_q, err_d;

   // A take and a give in the same cycle cancel out.
   always_comb begin
      credit_d = credit_q;
      err_d    = err_q;
      if (take && !give) begin
         credit_d = credit_q - CW'(1);
      end else if (give && !take) begin
         if (credit_q == CW'(NUM_LB)) begin
            err_d = 1'b1;
         end else begin
            credit_d = credit_q + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         credit_q <= CW'(NUM_LB);
         err_q    <= 1'b0;
      end else begin
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

   assign avail = (credit_q != '0);
   assign err   = err_q;

endmodule

// File: rtl/img_line_feeder.sv
// Unpacks 32-bit pixel words into one pixel per clock, throttled by line credits.
// Optional IMG_FEEDER_FRAME_EN adds a line counter and an end-of-frame pulse.
module img_line_feeder
   import img_pkg::*;
#(
   parameter int unsigned LINE_W = LINE_W_DEF,
   parameter int unsigned NUM_LB = NUM_LB_DEF,
   parameter int unsigned IMG_H  = IMG_H_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [WORD_W-1:0] i_s_data,
   input  logic              i_s_valid,
   output logic              o_s_ready,
   output logic [PIX_W-1:0]  o_pixel_data,
   output logic              o_pixel_data_valid,
   input  logic              i_line_done,
   output logic              o_credit_err,
   output logic              o_frame_done
);

   localparam int unsigned PC_W = cnt_w(LINE_W);

   if (((LINE_W % BYTES_PER_WORD) != 0) || (IMG_H == 0)) begin : g_param_chk
      $error("img_line_feeder: LINE_W must be a multiple of 4 and IMG_H nonzero");
   end

   feed_state_e       state_q, state_d;
   logic [WORD_W-1:0] hold_q, hold_d;
   logic [1:0]        idx_q, idx_d;
   logic [PC_W-1:0]   pcnt_q, pcnt_d;
   pixel_t            pix_q, pix_d;
   logic              pix_vld_q, pix_vld_d;

   logic avail, emit_c, last_byte_c, line_end_c, ready_c, accept_c;

   // SEND means the hold register is full.
   assign emit_c      = (state_q == SEND) && avail;
   assign last_byte_c = emit_c && (idx_q == 2'(BYTES_PER_WORD - 1));
   assign line_end_c  = emit_c && (pcnt_q == PC_W'(LINE_W - 1));
   assign ready_c     = !i_rst && ((state_q == FILL) || last_byte_c);
   assign accept_c    = i_s_valid && ready_c;

   img_credit_ctr #(.NUM_LB(NUM_LB)) u_credit (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .take  (line_end_c),
      .give  (i_line_done),
      .avail (avail),
      .err   (o_credit_err)
   );

   // An accept overrides the emit bookkeeping so a new word follows byte 3 with no bubble.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      idx_d     = idx_q;
      pcnt_d    = pcnt_q;
      pix_d     = pix_q;
      pix_vld_d = 1'b0;
      if (emit_c) begin
         pix_d     = hold_q[{idx_q, 3'b000} +: PIX_W];
         pix_vld_d = 1'b1;
         idx_d     = idx_q + 2'd1;
         pcnt_d    = line_end_c ? '0 : pcnt_q + PC_W'(1);
         if (last_byte_c) begin
            state_d = FILL;
         end
      end
      if (accept_c) begin
         hold_d  = i_s_data;
         idx_d   = '0;
         state_d = SEND;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= FILL;
         hold_q    <= '0;
         idx_q     <= '0;
         pcnt_q    <= '0;
         pix_q     <= '0;
         pix_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         idx_q     <= idx_d;
         pcnt_q    <= pcnt_d;
         pix_q     <= pix_d;
         pix_vld_q <= pix_vld_d;
      end
   end

   assign o_s_ready          = ready_c;
   assign o_pixel_data       = pix_q;
   assign o_pixel_data_valid = pix_vld_q;

`ifdef IMG_FEEDER_FRAME_EN
   localparam int unsigned LC_W = cnt_w(IMG_H);

   logic [LC_W-1:0] lcnt_q, lcnt_d;
   logic            fdone_q, fdone_d;

   // Frame pulse lands together with the last pixel's strobe.
   always_comb begin
      lcnt_d  = lcnt_q;
      fdone_d = 1'b0;
      if (line_end_c) begin
         if (lcnt_q == LC_W'(IMG_H - 1)) begin
            lcnt_d  = '0;
            fdone_d = 1'b1;
         end else begin
            lcnt_d = lcnt_q + LC_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         lcnt_q  <= '0;
         fdone_q <= 1'b0;
      end else begin
         lcnt_q  <= lcnt_d;
         fdone_q <= fdone_d;
      end
   end

   assign o_frame_done = fdone_q;
`else
   assign o_frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_img_line_feeder.sv
// Directed self-checking bench for img_line_feeder (LINE_W=512, NUM_LB=4, IMG_H=4).
module tb_img_line_feeder;

   localparam int unsigned LW  = 512;
   localparam int unsigned NLB = 4;
   localparam int unsigned IH  = 4;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_s_data;
   logic        i_s_valid;
   logic        o_s_ready;
   logic [7:0]  o_pixel_data;
   logic        o_pixel_data_valid;
   logic        i_line_done;
   logic        o_credit_err;
   logic        o_frame_done;

   int          tests = 0;
   int          fails = 0;
   int unsigned word_idx = 0;
   int unsigned exp_pix = 0;
   int          pix_cnt = 0;
   int          seq_err = 0;
   int          fd_cnt = 0;
   int          fd_pix = 0;
   int          cyc = 0;
   int          first_cyc = 0;
   int          last_cyc = 0;
   bit          chk_seq = 1'b0;

   always #5 i_clk = ~i_clk;

   img_line_feeder #(.LINE_W(LW), .NUM_LB(NLB), .IMG_H(IH)) dut (
      .i_clk              (i_clk),
      .i_rst              (i_rst),
      .i_s_data           (i_s_data),
      .i_s_valid          (i_s_valid),
      .o_s_ready          (o_s_ready),
      .o_pixel_data       (o_pixel_data),
      .o_pixel_data_valid (o_pixel_data_valid),
      .i_line_done        (i_line_done),
      .o_credit_err       (o_credit_err),
      .o_frame_done       (o_frame_done)
   );

   // Word n carries stream pixels 4n..4n+3, so pixel k of the stream is k mod 256.
   function automatic logic [31:0] mk_word(input int unsigned idx);
      logic [31:0] w;
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*idx + k);
      return w;
   endfunction

   // One clock: note the handshake before the edge, sample outputs 1 unit after it.
   task automatic step();
      bit acc;
      @(negedge i_clk);
      acc = i_s_valid && o_s_ready;
      @(posedge i_clk);
      #1;
      cyc++;
      if (acc) begin
         word_idx++;
         i_s_data = mk_word(word_idx);
      end
      if (o_pixel_data_valid) begin
         if (chk_seq && (o_pixel_data !== 8'(exp_pix))) seq_err++;
         exp_pix++;
         pix_cnt++;
         if (pix_cnt == 1) first_cyc = cyc;
         last_cyc = cyc;
      end
      if (o_frame_done) begin
         fd_cnt++;
         fd_pix = pix_cnt;
      end
   endtask

   task automatic do_reset();
      i_rst       = 1'b1;
      i_line_done = 1'b0;
      step();
      step();
      i_rst   = 1'b0;
      exp_pix = 4 * word_idx;
      pix_cnt = 0;
      seq_err = 0;
   endtask

   task automatic test_reset();
      i_rst       = 1'b1;
      i_s_valid   = 1'b1;
      i_line_done = 1'b0;
      word_idx    = 0;
      i_s_data    = mk_word(0);
      step();
      step();
      tests++; if (o_s_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", o_s_ready); end
      tests++; if (o_pixel_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", o_pixel_data); end
      tests++; if (o_pixel_data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_pixel_data_valid); end
      tests++; if (o_credit_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", o_credit_err); end
      tests++; if (o_frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame: got %b want 0", o_frame_done); end
      i_s_valid = 1'b0;
      i_rst     = 1'b0;
      #1;
      tests++; if (o_s_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", o_s_ready); end
      step();
   endtask

   task automatic test_unpack();
      logic [7:0] exp_b [4];
      exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
      chk_seq   = 1'b0;
      i_s_data  = 32'h4433_2211;
      i_s_valid = 1'b1;
      step();
      i_s_valid = 1'b0;
      tests++; if (o_pixel_data_valid !== 1'b0) begin fails++; $display("FAIL unpack_lat0: got %b want 0", o_pixel_data_valid); end
      for (int k = 0; k < 4; k++) begin
         step();
         tests++;
         if (o_pixel_data_valid !== 1'b1 || o_pixel_data !== exp_b[k]) begin
            fails++;
            $display("FAIL unpack_byte%0d: got v=%b d=%h want v=1 d=%h", k, o_pixel_data_valid, o_pixel_data, exp_b[k]);
         end
      end
      step();
      tests++; if (o_pixel_data_valid !== 1'b0) begin fails++; $display("FAIL unpack_end_valid: got %b want 0", o_pixel_data_valid); end
      tests++; if (o_pixel_data !== 8'h44) begin fails++; $display("FAIL unpack_hold_data: got %h want 44", o_pixel_data); end
   endtask

   task automatic test_credit_exhaust();
      i_s_valid = 1'b0;
      do_reset();
      chk_seq   = 1'b1;
      i_s_valid = 1'b1;
      repeat (2060) step();
      tests++; if (pix_cnt != 2048) begin fails++; $display("FAIL exhaust_count: got %0d want 2048", pix_cnt); end
      tests++; if (last_cyc - first_cyc + 1 != 2048) begin fails++; $display("FAIL exhaust_gapless: got span %0d want 2048", last_cyc - first_cyc + 1); end
      repeat (100) step();
      tests++; if (pix_cnt != 2048) begin fails++; $display("FAIL exhaust_stall: got %0d want 2048", pix_cnt); end
      tests++; if (o_s_ready !== 1'b0) begin fails++; $display("FAIL exhaust_ready: got %b want 0", o_s_ready); end
      i_line_done = 1'b1;
      step();
      i_line_done = 1'b0;
      tests++; if (o_pixel_data_valid !== 1'b0) begin fails++; $display("FAIL resume_early: got %b want 0", o_pixel_data_valid); end
      step();
      tests++; if (o_pixel_data_valid !== 1'b1) begin fails++; $display("FAIL resume_valid: got %b want 1", o_pixel_data_valid); end
      repeat (600) step();
      tests++; if (pix_cnt != 2560) begin fails++; $display("FAIL resume_count: got %0d want 2560", pix_cnt); end
      tests++; if (seq_err != 0) begin fails++; $display("FAIL exhaust_sequence: got %0d bad pixels want 0", seq_err); end
   endtask

   task automatic test_simultaneous();
      int n;
      i_s_valid = 1'b0;
      do_reset();
      chk_seq   = 1'b1;
      i_s_valid = 1'b1;
      n = 0;
      while (pix_cnt < 2047 && n < 3000) begin
         step();
         n++;
      end
      tests++; if (pix_cnt != 2047) begin fails++; $display("FAIL simul_reach: got %0d want 2047", pix_cnt); end
      i_line_done = 1'b1;
      step();
      i_line_done = 1'b0;
      tests++; if (o_pixel_data_valid !== 1'b1 || pix_cnt != 2048) begin fails++; $display("FAIL simul_lineend: got v=%b n=%0d want v=1 n=2048", o_pixel_data_valid, pix_cnt); end
      step();
      tests++; if (o_pixel_data_valid !== 1'b1) begin fails++; $display("FAIL simul_nogap: got %b want 1", o_pixel_data_valid); end
      repeat (700) step();
      tests++; if (pix_cnt != 2560) begin fails++; $display("FAIL simul_credit: got %0d want 2560", pix_cnt); end
      tests++; if (seq_err != 0) begin fails++; $display("FAIL simul_sequence: got %0d bad pixels want 0", seq_err); end
   endtask

   task automatic test_overflow();
      i_s_valid = 1'b0;
      do_reset();
      chk_seq = 1'b1;
      tests++; if (o_credit_err !== 1'b0) begin fails++; $display("FAIL ovf_pre: got %b want 0", o_credit_err); end
      i_line_done = 1'b1;
      step();
      i_line_done = 1'b0;
      tests++; if (o_credit_err !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", o_credit_err); end
      i_s_valid = 1'b1;
      repeat (2100) step();
      tests++; if (pix_cnt != 2048) begin fails++; $display("FAIL ovf_count: got %0d want 2048", pix_cnt); end
      tests++; if (o_credit_err !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", o_credit_err); end
      tests++; if (seq_err != 0) begin fails++; $display("FAIL ovf_sequence: got %0d bad pixels want 0", seq_err); end
      i_s_valid = 1'b0;
      do_reset();
      tests++; if (o_credit_err !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b want 0", o_credit_err); end
   endtask

   task automatic test_frame();
`ifdef IMG_FEEDER_FRAME_EN
      int n;
      i_s_valid = 1'b0;
      do_reset();
      fd_cnt    = 0;
      fd_pix    = 0;
      chk_seq   = 1'b1;
      i_s_valid = 1'b1;
      n = 0;
      while (pix_cnt < 2200 && n < 4000) begin
         step();
         n++;
         i_line_done = o_pixel_data_valid && (pix_cnt % 512 == 0);
      end
      i_line_done = 1'b0;
      tests++; if (fd_cnt != 1) begin fails++; $display("FAIL frame_pulses: got %0d want 1", fd_cnt); end
      tests++; if (fd_pix != 2048) begin fails++; $display("FAIL frame_position: got %0d want 2048", fd_pix); end
      tests++; if (seq_err != 0) begin fails++; $display("FAIL frame_sequence: got %0d bad pixels want 0", seq_err); end
`else
      tests++; if (fd_cnt != 0) begin fails++; $display("FAIL frame_off_pulses: got %0d want 0", fd_cnt); end
      tests++; if (o_frame_done !== 1'b0) begin fails++; $display("FAIL frame_off_level: got %b want 0", o_frame_done); end
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_unpack();
      test_credit_exhaust();
      test_simultaneous();
      test_overflow();
      test_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
